uart_rx: RTL and testbench

//   UART serial receiver; counterpart to the TX path on the UART interface. Recovers frames from
//   rx_serial (start, DATA_BITS LSB-first, optional parity, one stop bit) by mid-bit sampling and

---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART serial receiver with mid-bit sampling and parity/frame status
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic [1:0]           sync_q;
  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic [7:0]           data_q, data_d;
  logic                 done_q, done_d;
  logic                 active_q, active_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 bit_tick;

  assign rxs      = sync_q[1];
  // In DATA/PARITY/STOP the counter restarts at the previous sample, so a full
  // bit time later lands on the next bit centre without accumulating drift.
  assign bit_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = CW'(1);
          bit_d   = 3'd0;
          par_d   = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(H)) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = bit_tick ? '0 : cnt_q + CW'(1);
        if (bit_tick) begin
          sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
          par_d = par_q ^ rxs;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1))
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        cnt_d = bit_tick ? '0 : cnt_q + CW'(1);
        if (bit_tick) begin
          par_d   = par_q ^ rxs;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = bit_tick ? '0 : cnt_q + CW'(1);
        if (bit_tick) begin
          done_d                 = 1'b1;
          data_d                 = '0;
          data_d[DATA_BITS-1:0]  = sh_q;
          perr_d                 = (PARITY_EN != 0) ? (par_q ^ 1'(PARITY_ODD)) : 1'b0;
          ferr_d                 = ~rxs;
          state_d                = rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d == S_START) || (state_d == S_DATA) ||
               (state_d == S_PARITY) || (state_d == S_STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      data_q   <= 8'd0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx_serial};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      data_q   <= data_d;
      done_q   <= done_d;
      active_q <= active_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_done      = done_q;
  assign rx_active    = active_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int LATENCY = CPB / 2 + (8 + 1 + 1) * CPB + 1 + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_active;
  logic       parity_error;
  logic       frame_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         st;
  } exp_t;
  exp_t sb[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_done(rx_done), .rx_active(rx_active), .parity_error(parity_error),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rx_done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
        chk("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
        chk("frame_error", {31'd0, frame_error}, {31'd0, e.fe});
        chk("latency", cyc - e.st, LATENCY);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic stop_bit);
    exp_t e;
    e.d  = d;
    e.pe = (^d) ^ pb;
    e.fe = ~stop_bit;
    e.st = cyc;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pb);
    drive_bit(stop_bit);
  endtask

  initial begin
    #1;
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_done", {31'd0, rx_done}, 32'd0);
    chk("rst_active", {31'd0, rx_active}, 32'd0);
    chk("rst_perr", {31'd0, parity_error}, 32'd0);
    chk("rst_ferr", {31'd0, frame_error}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (20) @(negedge clk);

    // 4-cycle low glitch: must be rejected as a false start
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    chk("glitch_active_hi", {31'd0, rx_active}, 32'd1);
    repeat (16) @(negedge clk);
    chk("glitch_active_lo", {31'd0, rx_active}, 32'd0);
    chk("glitch_data", {24'd0, rx_data}, 32'hA5);
    chk("glitch_perr", {31'd0, parity_error}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_error}, 32'd0);
    repeat (16) @(negedge clk);

    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    send_frame(8'h12, 1'b0, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (20) @(negedge clk);

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);

    // reset in the middle of data bit 3
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_serial = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
    chk("mid_rst_done", {31'd0, rx_done}, 32'd0);
    chk("mid_rst_active", {31'd0, rx_active}, 32'd0);
    chk("mid_rst_perr", {31'd0, parity_error}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_error}, 32'd0);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1);

    repeat (4 * CPB) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("frame_count", n_done, 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
